// File: rtl/sext_pipe_pkg.sv
// Shared types for the LC-3 immediate/offset extractor: mode encoding, field widths, field slicer.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package sext_pkg;

  // Field-select codes carried alongside the IR word; 6 and 7 are illegal
  typedef enum logic [2:0] {
    MODE_IMM5  = 3'd0,
    MODE_OFF6  = 3'd1,
    MODE_OFF9  = 3'd2,
    MODE_OFF11 = 3'd3,
    MODE_TRAP8 = 3'd4,
    MODE_ZERO  = 3'd5
  } ext_mode_e;

  localparam int IMM5_W      = 5;
  localparam int OFF6_W      = 6;
  localparam int OFF9_W      = 9;
  localparam int OFF11_W     = 11;
  localparam int TRAP8_W     = 8;
  localparam int MAX_FIELD_W = 11;

  // Codes beyond ZERO have no field defined
  function automatic logic mode_illegal(input logic [2:0] mode);
    return (mode > 3'(MODE_ZERO));
  endfunction

  // Pull the selected field out of the low IR bits, zero-padded to MAX_FIELD_W
  function automatic logic [MAX_FIELD_W-1:0] slice_field(input logic [MAX_FIELD_W-1:0] ir,
                                                         input logic [2:0] mode);
    logic [MAX_FIELD_W-1:0] r;
    r = '0;
    case (mode)
      3'(MODE_IMM5):  r[IMM5_W-1:0]  = ir[IMM5_W-1:0];
      3'(MODE_OFF6):  r[OFF6_W-1:0]  = ir[OFF6_W-1:0];
      3'(MODE_OFF9):  r[OFF9_W-1:0]  = ir[OFF9_W-1:0];
      3'(MODE_OFF11): r[OFF11_W-1:0] = ir[OFF11_W-1:0];
      3'(MODE_TRAP8): r[TRAP8_W-1:0] = ir[TRAP8_W-1:0];
      default:        r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sext_pipe_if.sv
// Handshake bundle for sext_pipe: IR/mode/base in, extended result out, valid/ready on each side.
// Latency: n/a (wires only).
// Backpressure: in_ready and out_ready carry the stall in each direction.
interface sext_pipe_if #(
  parameter int DATA_W = 16,
  parameter int IR_W   = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [IR_W-1:0]   in_ir;
  logic [2:0]        in_mode;
  logic [DATA_W-1:0] in_base;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_carry;
  logic              out_err;

  // Producer of IR words and consumer of results
  modport master (
    output in_valid, in_ir, in_mode, in_base, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_err
  );

  // The extractor itself
  modport slave (
    input  in_valid, in_ir, in_mode, in_base, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_err
  );
endinterface

// File: rtl/sext_pipe_param.sv
// Width-generic field extender: replicates the field MSB (sign) or zeros into the upper bits.
// Latency: combinational.
// Backpressure: none.
module sext_param #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in_dat,
  input  logic             sign_en,
  output logic [OUT_W-1:0] out_dat
);
  localparam int EXT_W = OUT_W - IN_W;

  logic fill;

  // Upper fill bit is the field MSB for sext, zero for zext
  always_comb begin
    fill    = sign_en & in_dat[IN_W-1];
    out_dat = {{EXT_W{fill}}, in_dat};
  end
endmodule

// File: rtl/sext_pipe.sv
// Two-stage IR field extractor/extender (S1 slices the field, S2 extends it); SEXT_ADDR_ADD_EN adds base in S2.
// Latency: 2 cycles in_valid->out_valid, one item per cycle sustained.
// Backpressure: out_ready low holds S2; S1 holds once S2 is full; in_ready = S1 can advance (combinational).
module sext_pipe
  import sext_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IR_W   = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  sext_pipe_if.slave   bus
);

  // Narrower words cannot hold OFF11 plus sign, or the IR lacks the field bits
  if (DATA_W < 12) begin : g_bad_data_w
    $error("sext_pipe: DATA_W must be >= 12");
  end
  if (IR_W < 11) begin : g_bad_ir_w
    $error("sext_pipe: IR_W must be >= 11");
  end

  // IR bits above the widest field are never looked at
  if (IR_W > MAX_FIELD_W) begin : g_ir_hi
    logic unused_ir_hi;
    assign unused_ir_hi = ^bus.in_ir[IR_W-1:MAX_FIELD_W];
  end

  logic s2_adv;
  logic s1_adv;

  // Stage 1 state
  logic                   s1_valid_q, s1_valid_d;
  logic [MAX_FIELD_W-1:0] s1_field_q, s1_field_d;
  logic [2:0]             s1_mode_q,  s1_mode_d;
  logic                   s1_err_q,   s1_err_d;

  // Stage 2 state
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q,  s2_data_d;
  logic              s2_carry_q, s2_carry_d;
  logic              s2_err_q,   s2_err_d;

  // Per-mode extended values and the selected one
  logic [DATA_W-1:0] ext_imm5, ext_off6, ext_off9, ext_off11, ext_trap8;
  logic [DATA_W-1:0] ext_sel;
  logic [DATA_W-1:0] res_data;
  logic              res_carry;

`ifdef SEXT_ADDR_ADD_EN
  logic [DATA_W-1:0] s1_base_q, s1_base_d;
  logic [DATA_W:0]   sum;
`else
  logic unused_base;
  assign unused_base = ^bus.in_base;
`endif

  // Each stage may take a new item when it is empty or its contents move on
  always_comb begin
    s2_adv = !s2_valid_q || bus.out_ready;
    s1_adv = !s1_valid_q || s2_adv;
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_carry = s2_carry_q;
  assign bus.out_err   = s2_err_q;

  // S1 next state: capture the sliced field on an accepted input, else hold
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_field_d = s1_field_q;
    s1_mode_d  = s1_mode_q;
    s1_err_d   = s1_err_q;
`ifdef SEXT_ADDR_ADD_EN
    s1_base_d  = s1_base_q;
`endif
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_field_d = slice_field(bus.in_ir[MAX_FIELD_W-1:0], bus.in_mode);
        s1_mode_d  = bus.in_mode;
        s1_err_d   = mode_illegal(bus.in_mode);
`ifdef SEXT_ADDR_ADD_EN
        s1_base_d  = bus.in_base;
`endif
      end
    end
  end

  sext_param #(.IN_W(IMM5_W),  .OUT_W(DATA_W)) u_imm5  (.in_dat(s1_field_q[IMM5_W-1:0]),  .sign_en(1'b1), .out_dat(ext_imm5));
  sext_param #(.IN_W(OFF6_W),  .OUT_W(DATA_W)) u_off6  (.in_dat(s1_field_q[OFF6_W-1:0]),  .sign_en(1'b1), .out_dat(ext_off6));
  sext_param #(.IN_W(OFF9_W),  .OUT_W(DATA_W)) u_off9  (.in_dat(s1_field_q[OFF9_W-1:0]),  .sign_en(1'b1), .out_dat(ext_off9));
  sext_param #(.IN_W(OFF11_W), .OUT_W(DATA_W)) u_off11 (.in_dat(s1_field_q[OFF11_W-1:0]), .sign_en(1'b1), .out_dat(ext_off11));
  sext_param #(.IN_W(TRAP8_W), .OUT_W(DATA_W)) u_trap8 (.in_dat(s1_field_q[TRAP8_W-1:0]), .sign_en(1'b0), .out_dat(ext_trap8));

  // Pick the extender for the registered mode; ZERO and illegal codes give 0
  always_comb begin
    ext_sel = '0;
    case (s1_mode_q)
      3'(MODE_IMM5):  ext_sel = ext_imm5;
      3'(MODE_OFF6):  ext_sel = ext_off6;
      3'(MODE_OFF9):  ext_sel = ext_off9;
      3'(MODE_OFF11): ext_sel = ext_off11;
      3'(MODE_TRAP8): ext_sel = ext_trap8;
      default:        ext_sel = '0;
    endcase
  end

  // Result is either the extended value or base+ext with carry out
  always_comb begin
`ifdef SEXT_ADDR_ADD_EN
    sum       = {1'b0, s1_base_q} + {1'b0, ext_sel};
    res_data  = sum[DATA_W-1:0];
    res_carry = sum[DATA_W];
`else
    res_data  = ext_sel;
    res_carry = 1'b0;
`endif
  end

  // S2 next state: load from S1 when advancing; data regs keep last value across bubbles
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_carry_d = s2_carry_q;
    s2_err_d   = s2_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d  = res_data;
        s2_carry_d = res_carry;
        s2_err_d   = s1_err_q;
      end
    end
  end

  // Pipeline registers; reset discards anything in flight
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_field_q <= '0;
      s1_mode_q  <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_carry_q <= 1'b0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_field_q <= s1_field_d;
      s1_mode_q  <= s1_mode_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_carry_q <= s2_carry_d;
      s2_err_q   <= s2_err_d;
    end
  end

`ifdef SEXT_ADDR_ADD_EN
  // Base operand travels with its field through S1
  always_ff @(posedge Clk) begin
    if (Reset) s1_base_q <= '0;
    else       s1_base_q <= s1_base_d;
  end
`endif

endmodule

// File: tb/tb_sext_pipe.sv
// Bench for sext_pipe: fixed vectors, streaming/stall/reset sequences, random traffic vs. a scoreboard.
// Latency: n/a.
// Backpressure: drives out_ready low and random to exercise stalls.
module tb_sext_pipe;

  localparam int DW = 16;

  typedef struct {
    logic [15:0] data;
    logic        carry;
    logic        err;
  } exp_t;

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  mode;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   n_out;
  exp_t sb[$];
  logic prev_stall;
  logic [15:0] prev_data;
  logic prev_err;

  sext_pipe_if #(.DATA_W(DW), .IR_W(16)) bus ();

  sext_pipe #(.DATA_W(DW), .IR_W(16)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: take the field value, reinterpret as signed where the mode says so, wrap to 16 bits
  function automatic exp_t model(input logic [15:0] ir, input logic [2:0] mode, input logic [15:0] base);
    exp_t r;
    int w;
    bit sgn;
    int f;
    int v;
    logic [15:0] ext;
    logic [16:0] s;
    sgn = 1'b1;
    case (mode)
      3'd0: w = 5;
      3'd1: w = 6;
      3'd2: w = 9;
      3'd3: w = 11;
      3'd4: begin w = 8; sgn = 1'b0; end
      default: w = 0;
    endcase
    r.err = (mode >= 3'd6);
    if (w == 0) v = 0;
    else begin
      f = int'(ir) % (1 << w);
      v = f;
      if (sgn && f >= (1 << (w - 1))) v = f - (1 << w);
    end
    ext = 16'(v & 32'hFFFF);
`ifdef SEXT_ADDR_ADD_EN
    s = {1'b0, base} + {1'b0, ext};
    r.data  = s[15:0];
    r.carry = s[16];
`else
    s = {1'b0, base};
    r.data  = ext;
    r.carry = 1'b0;
`endif
    return r;
  endfunction

  // One cycle of traffic: drive at negedge, sample transfers 1ns later, score outputs
  task automatic cycle(input logic iv, input logic [15:0] ir, input logic [2:0] mode,
                       input logic [15:0] base, input logic ordy, output logic accepted);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_ir     = ir;
    bus.in_mode   = mode;
    bus.in_base   = base;
    bus.out_ready = ordy;
    #1;
    if (prev_stall) begin
      check("stall_valid_held", 32'(bus.out_valid), 32'd1);
      check("stall_data_held", 32'(bus.out_data), 32'(prev_data));
      check("stall_err_held", 32'(bus.out_err), 32'(prev_err));
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    prev_err   = bus.out_err;
    accepted = iv && bus.in_ready;
    if (accepted) sb.push_back(model(ir, mode, base));
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (sb.size() == 0) check("unexpected_output", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("sb_data", 32'(bus.out_data), 32'(e.data));
        check("sb_carry", 32'(bus.out_carry), 32'(e.carry));
        check("sb_err", 32'(bus.out_err), 32'(e.err));
      end
    end
  endtask

  task automatic drain(input string name);
    logic acc;
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      cycle(1'b0, 16'h0, 3'd0, 16'h0, 1'b1, acc);
      guard++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    prev_stall = 1'b0;
  endtask

  initial begin
    vec_t vecs[13];
    logic acc;
    int   n_acc;
    logic last_rdy;
    logic [15:0] r_ir, r_base;
    logic [2:0]  r_mode;
    logic        r_iv, r_or;

    n_checks = 0; n_pass = 0; n_out = 0;
    prev_stall = 1'b0; prev_data = '0; prev_err = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_ir = '0; bus.in_mode = '0; bus.in_base = '0; bus.out_ready = 1'b1;

    vecs[0]  = '{16'h001F, 3'd0, 16'hFFFF, 1'b0};
    vecs[1]  = '{16'h000F, 3'd0, 16'h000F, 1'b0};
    vecs[2]  = '{16'hF1E0, 3'd0, 16'h0000, 1'b0};
    vecs[3]  = '{16'h0020, 3'd1, 16'hFFE0, 1'b0};
    vecs[4]  = '{16'h001F, 3'd1, 16'h001F, 1'b0};
    vecs[5]  = '{16'h0100, 3'd2, 16'hFF00, 1'b0};
    vecs[6]  = '{16'h03FF, 3'd3, 16'h03FF, 1'b0};
    vecs[7]  = '{16'h0400, 3'd3, 16'hFC00, 1'b0};
    vecs[8]  = '{16'h00FF, 3'd4, 16'h00FF, 1'b0};
    vecs[9]  = '{16'hFE80, 3'd4, 16'h0080, 1'b0};
    vecs[10] = '{16'hFFFF, 3'd5, 16'h0000, 1'b0};
    vecs[11] = '{16'hFFFF, 3'd6, 16'h0000, 1'b1};
    vecs[12] = '{16'h1234, 3'd7, 16'h0000, 1'b1};

    // Reset held 3 cycles then released
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_out_carry", 32'(bus.out_carry), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single items, base 0 so the adder variant gives the same result
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_ir = vecs[i].ir; bus.in_mode = vecs[i].mode;
      bus.in_base = 16'h0; bus.out_ready = 1'b1;
      #1 check("vec_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_err", i), 32'(bus.out_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_carry", i), 32'(bus.out_carry), 32'd0);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_bubble_valid", i), 32'(bus.out_valid), 32'd0);
      check($sformatf("vec%0d_bubble_hold", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
    end

    // Back-to-back stream: results on consecutive cycles
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_ir = 16'h0100; bus.in_mode = 3'd2; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_ir = 16'h03FF; bus.in_mode = 3'd3;
    @(negedge clk);
    bus.in_ir = 16'h00FF; bus.in_mode = 3'd4;
    #1 check("stream0_valid", 32'(bus.out_valid), 32'd1);
    check("stream0_data", 32'(bus.out_data), 32'h0000FF00);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check("stream1_valid", 32'(bus.out_valid), 32'd1);
    check("stream1_data", 32'(bus.out_data), 32'h000003FF);
    @(negedge clk);
    #1 check("stream2_valid", 32'(bus.out_valid), 32'd1);
    check("stream2_data", 32'(bus.out_data), 32'h000000FF);
    @(negedge clk);

    // Stall: out_ready low 5 cycles with 3 items offered; only 2 fit
    n_acc = 0; last_rdy = 1'b1; n_out = 0;
    for (int c = 0; c < 5; c++) begin
      if (n_acc < 3) begin
        cycle(1'b1, 16'h0010 + 16'(n_acc), 3'd0, 16'h0, 1'b0, acc);
        last_rdy = bus.in_ready;
        if (acc) n_acc++;
      end
    end
    check("stall_accepted", 32'(n_acc), 32'd2);
    check("stall_in_ready", 32'(last_rdy), 32'd0);
    while (n_acc < 3) begin
      cycle(1'b1, 16'h0010 + 16'(n_acc), 3'd0, 16'h0, 1'b1, acc);
      if (acc) n_acc++;
    end
    drain("stall_drain");
    check("stall_delivered", 32'(n_out), 32'd3);

    // Reset while the pipe is full and stalled
    for (int c = 0; c < 3; c++) cycle(1'b1, 16'h03FF, 3'd7, 16'h0, 1'b0, acc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_data", 32'(bus.out_data), 32'd0);
    check("midrst_out_err", 32'(bus.out_err), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    prev_stall = 1'b0;

`ifdef SEXT_ADDR_ADD_EN
    // Base plus negative offset wraps with carry out
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_ir = 16'h0020; bus.in_mode = 3'd1;
    bus.in_base = 16'hFFF0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("add_data", 32'(bus.out_data), 32'h0000FFD0);
    check("add_carry", 32'(bus.out_carry), 32'd1);
    @(negedge clk);
`endif

    // Random traffic against the scoreboard
    for (int c = 0; c < 600; c++) begin
      r_iv   = ($urandom_range(0, 9) < 7);
      r_or   = ($urandom_range(0, 9) < 6);
      r_ir   = 16'($urandom);
      r_mode = 3'($urandom_range(0, 7));
      r_base = 16'($urandom);
      cycle(r_iv, r_ir, r_mode, r_base, r_or, acc);
    end
    drain("rand_drain");

    // Reset once more to confirm recovery after random traffic
    do_reset(2);
    #1 check("final_in_ready", 32'(bus.in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
